// File: rtl/video_comp_pkg.sv
// Shared register map, reset defaults and layer-bus helper for the layer compositor.
package video_comp_pkg;

    localparam logic [13:0] REG_EN  = 14'd0;
    localparam logic [13:0] REG_BG  = 14'd1;
    localparam logic [13:0] REG_KEY = 14'd2;
    localparam logic [13:0] REG_CLR = 14'd3;

    localparam logic [11:0] BG_DEFAULT = 12'h008;

    // Helper bounds; callers zero-extend their flat bus to MaxBus bits.
    localparam int unsigned MaxBus = 256;
    localparam int unsigned MaxCd  = 32;

    function automatic logic [MaxCd-1:0] layer_at(input logic [MaxBus-1:0] bus,
                                                  input int unsigned idx,
                                                  input int unsigned cd);
        logic [MaxBus-1:0] sh;
        logic [MaxCd-1:0]  r;
        sh = bus >> (idx * cd);
        for (int unsigned b = 0; b < MaxCd; b++) begin
            r[b] = (b < cd) ? sh[b] : 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/comp_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module comp_fifo #(
    parameter int unsigned Width = 13,
    parameter int unsigned Depth = 8,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);
    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/video_layer_compositor.sv
// Priority/chroma-key layer merger with credit-gated pixel issue and an output FIFO
// that absorbs sync-core backpressure for the fixed-latency layer pipeline.
module video_layer_compositor
    import video_comp_pkg::*;
#(
    parameter int unsigned CD        = 12,
    parameter int unsigned NL        = 4,
    parameter int unsigned HMAX      = 640,
    parameter int unsigned VMAX      = 480,
    parameter int unsigned LAT       = 2,
    parameter int unsigned FD        = 8,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             write,
    input  logic [13:0]      addr,
    input  logic [31:0]      wr_data,
    output logic [10:0]      x,
    output logic [10:0]      y,
    output logic             inc,
    input  logic [NL*CD-1:0] layer_rgb,
    output logic [CD:0]      so_data,
    output logic             so_valid,
    input  logic             so_ready
);

    localparam int unsigned CntW = $clog2(FD + 1);
    localparam int unsigned IfW  = $clog2(LAT + 2);

    logic [NL-1:0]   en_q;
    logic [CD-1:0]   bg_q, key_q, rgb_q, comp_rgb;
    logic            clr_q, reg_wr, issue_fs;
    logic [10:0]     x_q, y_q;
    logic [LAT:0]    vld_q, fs_q;
    logic [CntW-1:0] fifo_cnt;
    logic [IfW-1:0]  in_flight;
    logic            unused_wr;

    assign unused_wr = ^wr_data[31:CD];
    assign reg_wr    = cs && write;

    // A pending sync_clr redirects the next issued pixel to the frame origin.
    assign x        = clr_q ? '0 : x_q;
    assign y        = clr_q ? '0 : y_q;
    assign issue_fs = (x == '0) && (y == '0);

    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= int'(LAT); i++) begin
            if (vld_q[i]) in_flight = in_flight + IfW'(1);
        end
    end

    // Every outstanding pixel already owns a FIFO slot, so a push can never find it full.
    assign inc = !reset && ((32'(fifo_cnt) + 32'(in_flight)) < FD);

    always_comb begin
        logic [CD-1:0] lyr;
        comp_rgb = bg_q;
        for (int i = int'(NL) - 1; i >= 0; i--) begin
            lyr = CD'(layer_at(MaxBus'(layer_rgb), unsigned'(i), CD));
            if (en_q[i] && (lyr != key_q)) comp_rgb = lyr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q  <= '1;
            bg_q  <= CD'(BG_DEFAULT);
            key_q <= KEY_COLOR;
            clr_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            vld_q <= '0;
            fs_q  <= '0;
            rgb_q <= '0;
        end else begin
            if (reg_wr) begin
                case (addr)
                    REG_EN:  en_q  <= wr_data[NL-1:0];
                    REG_BG:  bg_q  <= wr_data[CD-1:0];
                    REG_KEY: key_q <= wr_data[CD-1:0];
                    default: ;
                endcase
            end
            clr_q <= (clr_q && !inc) || (reg_wr && (addr == REG_CLR));
            vld_q <= {vld_q[LAT-1:0], inc};
            fs_q  <= {fs_q[LAT-1:0], inc && issue_fs};
            rgb_q <= comp_rgb;
            if (inc) begin
                if (x == 11'(HMAX - 1)) begin
                    x_q <= '0;
                    y_q <= (y == 11'(VMAX - 1)) ? '0 : y + 1'b1;
                end else begin
                    x_q <= x + 1'b1;
                    y_q <= y;
                end
            end
        end
    end

    comp_fifo #(
        .Width(CD + 1),
        .Depth(FD),
        .CntW (CntW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (vld_q[LAT]),
        .push_data_i({rgb_q, fs_q[LAT]}),
        .pop_i      (so_valid && so_ready),
        .data_o     (so_data),
        .valid_o    (so_valid),
        .count_o    (fifo_cnt)
    );

endmodule

// File: tb/tb_video_layer_compositor.sv
// Randomised bench for video_layer_compositor against a queue-based pixel model.
module tb_video_layer_compositor;

    localparam int unsigned CD   = 12;
    localparam int unsigned NL   = 4;
    localparam int unsigned HMAX = 8;
    localparam int unsigned VMAX = 4;
    localparam int unsigned LAT  = 2;
    localparam int unsigned FD   = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cs, write;
    logic [13:0]      addr;
    logic [31:0]      wr_data;
    logic [10:0]      x, y;
    logic             inc;
    logic [NL*CD-1:0] layer_rgb;
    logic [CD:0]      so_data;
    logic             so_valid, so_ready;

    video_layer_compositor #(
        .CD(CD), .NL(NL), .HMAX(HMAX), .VMAX(VMAX), .LAT(LAT), .FD(FD), .KEY_COLOR(12'h000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .x        (x),
        .y        (y),
        .inc      (inc),
        .layer_rgb(layer_rgb),
        .so_data  (so_data),
        .so_valid (so_valid),
        .so_ready (so_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus controls
    int          lay_mode   = 0;
    int          ready_mode = 0;
    logic [11:0] tb_key     = 12'h000;
    bit          frame_chk  = 1'b1;

    initial begin
        layer_rgb = '0;
        forever begin
            @(posedge clk); #1;
            case (lay_mode)
                0: layer_rgb = {4{tb_key}};
                1: layer_rgb = {12'hF00, 12'h00F, 12'h0F0, tb_key};
                default: begin
                    for (int i = 0; i < int'(NL); i++) begin
                        layer_rgb[i*CD +: CD] = ($urandom_range(0, 2) == 0) ? tb_key
                                                                            : 12'($urandom);
                    end
                end
            endcase
        end
    end

    initial begin
        so_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: so_ready = 1'b1;
                1: so_ready = 1'b0;
                default: so_ready = ($urandom_range(0, 99) < 30);
            endcase
        end
    end

    // Behavioural model: every issued coordinate is queued, composited LAT cycles later
    // from the bus and the register shadows, and expected in issue order at the output.
    typedef struct { int c; int px; int py; bit fs; } iss_t;
    iss_t        iq[$];
    logic [12:0] eq[$];
    int          cyc = 0, issued = 0, popped = 0, mx = 0, my = 0;
    bit          mclr = 0;
    logic [3:0]  men = 4'hF;
    logic [11:0] mbg = 12'h008, mkey = 12'h000;
    int          words_since_fs = -1;
    int          pop_cnt = 0;
    logic [12:0] last_word = '0;

    function automatic logic [11:0] ref_pix(input logic [NL*CD-1:0] bus);
        for (int i = 0; i < int'(NL); i++) begin
            if (men[i] && (bus[i*CD +: CD] != mkey)) return bus[i*CD +: CD];
        end
        return mbg;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            check("reset_so_valid", 64'(so_valid), 64'(0));
            check("reset_inc", 64'(inc), 64'(0));
            iq.delete(); eq.delete();
            issued = 0; popped = 0; mx = 0; my = 0; mclr = 0;
            men = 4'hF; mbg = 12'h008; mkey = 12'h000; words_since_fs = -1;
        end else begin
            cyc++;
            check("inc_credit", 64'(inc), 64'((issued - popped) < int'(FD)));
            check("no_overflow", 64'((issued - popped) <= int'(FD)), 64'(1));
            if (iq.size() > 0 && iq[0].c == cyc - int'(LAT)) begin
                iss_t r;
                r = iq.pop_front();
                eq.push_back({ref_pix(layer_rgb), r.fs});
            end
            if (inc) begin
                iss_t r;
                r.c  = cyc;
                r.px = mclr ? 0 : mx;
                r.py = mclr ? 0 : my;
                r.fs = (r.px == 0) && (r.py == 0);
                mclr = 0;
                check("issue_x", 64'(x), 64'(r.px));
                check("issue_y", 64'(y), 64'(r.py));
                if (r.px == int'(HMAX) - 1) begin
                    mx = 0;
                    my = (r.py == int'(VMAX) - 1) ? 0 : r.py + 1;
                end else begin
                    mx = r.px + 1;
                    my = r.py;
                end
                iq.push_back(r);
                issued++;
            end
            if (so_valid && so_ready) begin
                if (eq.size() == 0) begin
                    check("pop_unexpected", 64'(so_data), 64'('1));
                end else begin
                    check("so_data", 64'(so_data), 64'(eq.pop_front()));
                end
                popped++;
                if (so_data[0]) begin
                    if (frame_chk && words_since_fs >= 0)
                        check("frame_len", 64'(words_since_fs), 64'(HMAX * VMAX));
                    words_since_fs = 1;
                end else if (words_since_fs >= 0) begin
                    words_since_fs++;
                end
                last_word = so_data;
                pop_cnt++;
            end
            if (cs && write) begin
                case (addr)
                    14'd0: men  = wr_data[3:0];
                    14'd1: mbg  = wr_data[11:0];
                    14'd2: mkey = wr_data[11:0];
                    14'd3: mclr = 1;
                    default: ;
                endcase
            end
        end
    end

    task automatic reg_write(input logic [13:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        if (a == 14'd2) tb_key = d[11:0];
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic wait_pop(input string name);
        int start;
        bit got;
        start = pop_cnt;
        got   = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk); #1;
            if (pop_cnt != start) got = 1;
        end
        if (!got) check(name, 64'(0), 64'(1));
    endtask

    task automatic wait_issue_at(input string name, input int wx, input int wy);
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk); #1;
            if (inc && x == 11'(wx) && y == 11'(wy)) got = 1;
        end
        check(name, 64'(got), 64'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit got;
        reset = 1'b1; cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // All layers keyed: background everywhere, first word opens a frame.
        wait_pop("first_word_timeout");
        check("first_word_bg_fs", 64'(last_word), 64'(13'h011));
        repeat (80) @(posedge clk);

        // Priority: layer0 keyed, layer1 wins; masking layer1 falls through to layer2.
        lay_mode = 1;
        repeat (20) @(posedge clk);
        wait_pop("prio_timeout");
        check("prio_layer1", 64'(last_word[12:1]), 64'(12'h0F0));
        reg_write(14'd0, 32'h0000_000D);
        repeat (30) @(posedge clk);
        wait_pop("mask_timeout");
        check("mask_layer2", 64'(last_word[12:1]), 64'(12'h00F));

        // Backpressure: issue must stall with exactly FD pixels outstanding.
        ready_mode = 1;
        repeat (50) @(negedge clk);
        #1;
        check("bp_inc_stalled", 64'(inc), 64'(0));
        check("bp_outstanding", 64'(issued - popped), 64'(FD));
        ready_mode = 0;
        repeat (40) @(posedge clk);

        // Random traffic and register updates at 30% ready duty.
        lay_mode   = 2;
        ready_mode = 2;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            cs = 1'b0; write = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                cs = 1'b1; write = 1'b1;
                case ($urandom_range(0, 3))
                    0: begin addr = 14'd0; wr_data = $urandom; end
                    1: begin addr = 14'd1; wr_data = $urandom; end
                    2: begin
                        addr = 14'd2; wr_data = 32'($urandom_range(0, 3));
                        tb_key = wr_data[11:0];
                    end
                    default: begin addr = 14'd9; wr_data = $urandom; end
                endcase
            end
        end
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
        ready_mode = 0;
        repeat (40) @(posedge clk);

        // sync_clr mid-frame: next issue restarts at the origin.
        lay_mode  = 0;
        frame_chk = 1'b0;
        wait_issue_at("clr_find", 3, 2);
        reg_write(14'd3, 32'h1);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk); #1;
            if (inc) begin
                got = 1;
                check("clr_x0", 64'(x), 64'(0));
                check("clr_y0", 64'(y), 64'(0));
            end
        end
        check("clr_issue_seen", 64'(got), 64'(1));
        repeat (20) @(posedge clk);

        // Reset mid-line.
        wait_issue_at("rst_find", 5, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst_so_valid_now", 64'(so_valid), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        frame_chk = 1'b1;
        @(negedge clk); #1;
        check("rst_first_inc", 64'(inc), 64'(1));
        check("rst_first_xy", 64'({x, y}), 64'(0));
        wait_pop("rst_pop_timeout");
        check("rst_first_fs", 64'(last_word[0]), 64'(1));
        repeat (100) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
